// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule sigma functions and the W-scheduler state type.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;
  localparam int SHA256_WIN    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } w_sched_state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sha256_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sha256_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational message-schedule expander: next word from window taps 0, 1, 9 and 14.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] win0,
  input  logic [31:0] win1,
  input  logic [31:0] win9,
  input  logic [31:0] win14,
  output logic [31:0] w_new
);

  assign w_new = sha256_sigma1(win14) + win9 + sha256_sigma0(win1) + win0;

endmodule

// File: rtl/sha256_w_scheduler.sv
// SHA-256 message-schedule sequencer: loads a 512-bit block and streams W[0..63].
// Define SHA256_WSCHED_STALL_EN to let w_ready gate every transfer (backpressure).
module sha256_w_scheduler
  import sha256_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         done
);

  w_sched_state_t state_q, state_d;
  logic [5:0]     w_idx_q, w_idx_d;
  logic           w_valid_q, w_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [31:0] window_q   [SHA256_WIN];
  logic [31:0] window_d   [SHA256_WIN];
  logic [31:0] load_word  [SHA256_WIN];
  logic [31:0] shift_word [SHA256_WIN];
  logic [31:0] w_new;

  logic xfer;
  logic load_en;
  logic shift_en;

`ifdef SHA256_WSCHED_STALL_EN
  assign xfer = w_valid_q & w_ready;
`else
  // Fixed-rate stream: the consumer is assumed to always take the word.
  logic w_ready_unused;
  assign w_ready_unused = w_ready;
  assign xfer = w_valid_q;
`endif

  assign load_en  = (state_q == ST_IDLE) && start;
  assign shift_en = (state_q == ST_STREAM) && xfer;

  sha256_w_expand u_expand (
    .win0  (window_q[0]),
    .win1  (window_q[1]),
    .win9  (window_q[9]),
    .win14 (window_q[14]),
    .w_new (w_new)
  );

  // Word 0 is the most significant 32 bits of the block.
  genvar gi;
  generate
    for (gi = 0; gi < SHA256_WIN; gi++) begin : g_win
      assign load_word[gi] = block_in[511-32*gi -: 32];
      if (gi == SHA256_WIN-1) begin : g_tail
        assign shift_word[gi] = w_new;
      end else begin : g_body
        assign shift_word[gi] = window_q[gi+1];
      end
      assign window_d[gi] = load_en  ? load_word[gi]  :
                            shift_en ? shift_word[gi] :
                                       window_q[gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    w_idx_d   = w_idx_q;
    w_valid_d = w_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_STREAM;
          w_idx_d   = 6'd0;
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          w_idx_d = w_idx_q + 6'd1;
          if (w_idx_q == 6'(SHA256_ROUNDS-1)) begin
            state_d   = ST_DONE;
            w_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        w_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      w_idx_q   <= 6'd0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < SHA256_WIN; i++) begin
        window_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      w_idx_q   <= w_idx_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < SHA256_WIN; i++) begin
        window_q[i] <= window_d[i];
      end
    end
  end

  assign w_out   = window_q[0];
  assign w_idx   = w_idx_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sha256_w_scheduler.sv
// Self-checking bench for sha256_w_scheduler against a direct W[t] recurrence model.
module tb_sha256_w_scheduler;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         w_ready = 1'b1;
  logic         busy, w_valid, done;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  always #5 CLK = ~CLK;

  sha256_w_scheduler dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .block_in (block_in),
    .busy     (busy),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .w_idx    (w_idx),
    .done     (done)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void build_w(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // mode: 0 ready=1, 1 random ready, 2 ready low 5 cycles at idx 20, 3 ready=0
  task automatic stream_block(input logic [511:0] blk, input int mode, input int poke_at);
    int  exp_idx, cycles, stall_cnt;
    bit  rdy, xfer, poked;
    build_w(blk);
    @(negedge CLK);
    start = 1'b1; block_in = blk; w_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0; block_in = rand_block();
    exp_idx = 0; cycles = 0; stall_cnt = 0; poked = 1'b0;
    while (exp_idx < 64 && cycles < 1000) begin
      checks++;
      if (w_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL stream_flags idx=%0d: got valid=%b busy=%b done=%b expected 1 1 0",
                 exp_idx, w_valid, busy, done);
      checks++;
      if (w_idx !== 6'(exp_idx)) begin
        failures++;
        $display("FAIL stream_idx: got %0d expected %0d", w_idx, exp_idx);
      end
      checks++;
      if (w_out !== exp_w[exp_idx]) begin
        failures++;
        $display("FAIL stream_word W[%0d]: got %08h expected %08h", exp_idx, w_out, exp_w[exp_idx]);
      end
      if (w_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) failures++;
      obs_w[exp_idx] = w_out;
      start = 1'b0;
      if (exp_idx == poke_at && !poked) begin
        start = 1'b1; block_in = rand_block(); poked = 1'b1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = !(exp_idx == 20 && stall_cnt < 5);
          if (!rdy) stall_cnt++;
        end
        default: rdy = 1'b0;
      endcase
`ifdef SHA256_WSCHED_STALL_EN
      xfer = rdy;
`else
      xfer = 1'b1;
`endif
      w_ready = rdy;
      if (xfer) exp_idx++;
      cycles++;
      @(negedge CLK);
    end
    start = 1'b0; w_ready = 1'b1;
    checks++;
    if (cycles >= 1000) begin
      failures++;
      $display("FAIL stream_timeout: got idx %0d expected 64 words", exp_idx);
    end
    checks++;
    if (done !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got done=%b valid=%b busy=%b expected 1 0 0", done, w_valid, busy);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle: got done=%b valid=%b busy=%b expected 0 0 0", done, w_valid, busy);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, w_valid, done, w_idx, w_out} !== 41'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b valid=%b done=%b idx=%0d out=%08h expected all 0",
               busy, w_valid, done, w_idx, w_out);
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, w_valid, done, w_idx, w_out} !== 41'd0) begin
      failures++;
      $display("FAIL idle_hold: got busy=%b valid=%b done=%b idx=%0d out=%08h expected all 0",
               busy, w_valid, done, w_idx, w_out);
    end
  endtask

  task automatic test_abc();
    logic [511:0] abc;
    abc = {32'h61626380, 448'd0, 32'h00000018};
    stream_block(abc, 0, -1);
    checks++;
    if (obs_w[0] !== 32'h61626380) begin
      failures++; $display("FAIL abc_w0: got %08h expected 61626380", obs_w[0]);
    end
    checks++;
    if (obs_w[15] !== 32'h00000018) begin
      failures++; $display("FAIL abc_w15: got %08h expected 00000018", obs_w[15]);
    end
    checks++;
    if (obs_w[16] !== 32'h61626380) begin
      failures++; $display("FAIL abc_w16: got %08h expected 61626380", obs_w[16]);
    end
    checks++;
    if (obs_w[17] !== 32'h000F0000) begin
      failures++; $display("FAIL abc_w17: got %08h expected 000f0000", obs_w[17]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) stream_block(rand_block(), 1, -1);
  endtask

  task automatic test_backpressure();
    stream_block(rand_block(), 2, -1);
  endtask

  task automatic test_start_ignored();
    stream_block(rand_block(), 0, 30);
  endtask

  task automatic test_no_ready();
`ifdef SHA256_WSCHED_STALL_EN
    stream_block(rand_block(), 0, -1);
`else
    stream_block(rand_block(), 3, -1);
`endif
  endtask

  task automatic test_reset_mid();
    int guard;
    @(negedge CLK);
    start = 1'b1; block_in = rand_block(); w_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    guard = 0;
    while (w_idx !== 6'd40 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++; $display("FAIL reset_mid_reach: got idx %0d expected 40", w_idx);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({busy, w_valid, done, w_idx, w_out} !== 41'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: got busy=%b valid=%b done=%b idx=%0d out=%08h expected all 0",
               busy, w_valid, done, w_idx, w_out);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({busy, w_valid, done, w_idx, w_out} !== 41'd0) begin
      failures++;
      $display("FAIL reset_mid_idle: got busy=%b valid=%b idx=%0d out=%08h expected all 0",
               busy, w_valid, w_idx, w_out);
    end
    stream_block(rand_block(), 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [511:0] a, b;
    a = rand_block();
    b = rand_block();
    @(negedge CLK);
    start = 1'b1; block_in = a; w_ready = 1'b1;
    for (int blk = 0; blk < 2; blk++) begin
      build_w(blk == 0 ? a : b);
      @(negedge CLK);
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (w_valid !== 1'b1 || w_idx !== 6'(k) || w_out !== exp_w[k]) begin
          failures++;
          $display("FAIL b2b_word blk=%0d k=%0d: got valid=%b idx=%0d out=%08h expected 1 %0d %08h",
                   blk, k, w_valid, w_idx, w_out, k, exp_w[k]);
        end
        if (k == 0) begin
          if (blk == 0) block_in = b;
          else start = 1'b0;
        end
        @(negedge CLK);
      end
      checks++;
      if (done !== 1'b1) begin
        failures++; $display("FAIL b2b_done blk=%0d: got %b expected 1", blk, done);
      end
      @(negedge CLK);
      checks++;
      if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle_gap blk=%0d: got valid=%b busy=%b done=%b expected 0 0 0",
                 blk, w_valid, busy, done);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_random();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_no_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
